// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache: combinational hit path, three-state refill FSM
// fetching one 128-bit block per miss from instruction memory.
module icache_direct_mapped #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 3,
    parameter int BLOCK_BITS = 128
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    ADDRESS,
    output logic [31:0]                    INSTRUCTION,
    output logic                           BUSYWAIT,
    output logic                           MEM_READ,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    input  logic [BLOCK_BITS-1:0]          MEM_READDATA,
    input  logic                           MEM_BUSYWAIT
);

    localparam int LINES         = 1 << INDEX_BITS;
    localparam int BLK_ADDR_BITS = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_FETCH = 2'd1,
        UPDATE    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [LINES-1:0]         valid_q, valid_d;
    logic [TAG_BITS-1:0]      tag_q  [LINES];
    logic [TAG_BITS-1:0]      tag_d  [LINES];
    logic [BLOCK_BITS-1:0]    data_q [LINES];
    logic [BLOCK_BITS-1:0]    data_d [LINES];
    logic [BLK_ADDR_BITS-1:0] fill_addr_q, fill_addr_d;
    logic [BLOCK_BITS-1:0]    fill_data_q, fill_data_d;

    logic [1:0]               addr_word;
    logic [INDEX_BITS-1:0]    addr_index;
    logic [TAG_BITS-1:0]      addr_tag;
    logic [INDEX_BITS-1:0]    fill_index;
    logic [TAG_BITS-1:0]      fill_tag;
    logic                     hit;
    logic                     unused_addr;

    assign addr_word   = ADDRESS[3:2];
    assign addr_index  = ADDRESS[INDEX_BITS+3:4];
    assign addr_tag    = ADDRESS[BLK_ADDR_BITS+3:INDEX_BITS+4];
    assign unused_addr = ^{ADDRESS[31:BLK_ADDR_BITS+4], ADDRESS[1:0]};

    assign fill_index = fill_addr_q[INDEX_BITS-1:0];
    assign fill_tag   = fill_addr_q[BLK_ADDR_BITS-1:INDEX_BITS];

    assign hit         = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
    assign INSTRUCTION = data_q[addr_index][{addr_word, 5'd0} +: 32];
    assign BUSYWAIT    = (state_q != IDLE) || !hit;

    // The request address is the registered fill address, so it stays put for the whole fetch.
    assign MEM_READ    = (state_q == MEM_FETCH);
    assign MEM_ADDRESS = fill_addr_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d     = MEM_FETCH;
                    fill_addr_d = {addr_tag, addr_index};
                end
            end
            MEM_FETCH: begin
                if (!MEM_BUSYWAIT) begin
                    state_d     = UPDATE;
                    fill_data_d = MEM_READDATA;
                end
            end
            UPDATE: begin
                // Install from the captured copy; memory data is no longer guaranteed here.
                data_d[fill_index]  = fill_data_q;
                tag_d[fill_index]   = fill_tag;
                valid_d[fill_index] = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            fill_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            fill_addr_q <= fill_addr_d;
        end
    end

    always_ff @(posedge CLK) begin
        tag_q       <= tag_d;
        data_q      <= data_d;
        fill_data_q <= fill_data_d;
    end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: a latency-programmable memory responder plus
// an arithmetic reference cache (valid/tag per index) predicting hits, stall length and data.
module tb_icache_direct_mapped;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [31:0]  ADDRESS = 32'h0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [127:0] mem_blocks [64];
    int           mem_lat = 5;
    bit           zero_lat = 1'b0;
    int           lat_cnt = 0;

    bit           ref_valid [8];
    int unsigned  ref_tag   [8];

    icache_direct_mapped dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory: busy for mem_lat-1 cycles of a read, valid data only on the cycle busy drops.
    always @(negedge CLK) begin
        if (zero_lat) begin
            MEM_BUSYWAIT = 1'b0;
            MEM_READDATA = mem_blocks[MEM_ADDRESS];
        end else if (MEM_READ === 1'b1) begin
            if (lat_cnt < mem_lat - 1) begin
                lat_cnt++;
                MEM_BUSYWAIT = 1'b1;
                MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = mem_blocks[MEM_ADDRESS];
            end
        end else begin
            lat_cnt      = 0;
            MEM_BUSYWAIT = 1'b1;
            MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // A miss stalls for one cycle in each of the idle-detect and update states plus every
    // cycle the read request is outstanding (at least one, even with an always-ready memory).
    function automatic void predict(input logic [31:0] addr, output int exp_busy,
                                    output logic [31:0] exp_instr, output bit exp_miss,
                                    output logic [5:0] exp_maddr);
        int unsigned  tag, idx, word;
        logic [127:0] block;
        tag       = (addr >> 7) % 8;
        idx       = (addr >> 4) % 8;
        word      = (addr >> 2) % 4;
        exp_miss  = !(ref_valid[idx] && ref_tag[idx] == tag);
        exp_busy  = exp_miss ? 2 + (zero_lat ? 1 : mem_lat) : 0;
        exp_maddr = 6'(tag * 8 + idx);
        block     = mem_blocks[tag * 8 + idx];
        exp_instr = block[word * 32 +: 32];
        if (exp_miss) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
        end
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    // Presents addr just after an edge and counts BUSYWAIT-high cycles until it drops.
    task automatic run_fetch(input logic [31:0] addr, input bit drop_reset, output int busy_cnt,
                             output logic [31:0] instr, output bit read_seen,
                             output logic [5:0] maddr, output bit timed_out);
        @(posedge CLK);
        #1;
        ADDRESS = addr;
        if (drop_reset) RESET = 1'b0;
        busy_cnt  = 0;
        read_seen = 1'b0;
        maddr     = '0;
        timed_out = 1'b0;
        @(negedge CLK);
        while (BUSYWAIT !== 1'b0) begin
            busy_cnt++;
            if (MEM_READ === 1'b1) begin
                read_seen = 1'b1;
                maddr     = MEM_ADDRESS;
            end
            if (busy_cnt > 200) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (MEM_READ !== 1'b0) read_seen = 1'b1;
        instr = INSTRUCTION;
    endtask

    task automatic test_reset();
        RESET   = 1'b1;
        ADDRESS = 32'h0;
        clear_ref();
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (BUSYWAIT !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busywait: got %b expected 1", BUSYWAIT);
        end
        n_cmp++;
        if (MEM_READ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_read: got %b expected 0", MEM_READ);
        end
        n_cmp++;
        if (MEM_ADDRESS !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_mem_address: got %h expected 00", MEM_ADDRESS);
        end
    endtask

    task automatic test_cold_miss();
        int busy, exp_busy;
        logic [31:0] instr, exp_instr;
        logic [5:0] maddr, exp_maddr;
        bit rd, to, exp_miss;
        mem_lat = 5;
        predict(32'h0, exp_busy, exp_instr, exp_miss, exp_maddr);
        run_fetch(32'h0, 1'b1, busy, instr, rd, maddr, to);
        n_cmp++;
        if (to || busy !== 7) begin
            n_fail++;
            $display("FAIL cold_busy_cycles: got %0d expected 7", busy);
        end
        n_cmp++;
        if (!rd || maddr !== 6'h00) begin
            n_fail++;
            $display("FAIL cold_mem_address: got %h (read %b) expected 00", maddr, rd);
        end
        n_cmp++;
        if (instr !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL cold_instruction: got %h expected 11111111", instr);
        end
    endtask

    task automatic test_same_block_hits();
        logic [31:0] addrs [3] = '{32'h04, 32'h08, 32'h0C};
        logic [31:0] words [3] = '{32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        int busy, exp_busy;
        logic [31:0] instr, exp_instr;
        logic [5:0] maddr, exp_maddr;
        bit rd, to, exp_miss;
        for (int i = 0; i < 3; i++) begin
            predict(addrs[i], exp_busy, exp_instr, exp_miss, exp_maddr);
            run_fetch(addrs[i], 1'b0, busy, instr, rd, maddr, to);
            n_cmp++;
            if (to || busy !== 0 || rd) begin
                n_fail++;
                $display("FAIL hit_%0d_stall: busy %0d read %b expected 0 and 0", i, busy, rd);
            end
            n_cmp++;
            if (instr !== words[i]) begin
                n_fail++;
                $display("FAIL hit_%0d_instruction: got %h expected %h", i, instr, words[i]);
            end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] addrs [2] = '{32'h80, 32'h00};
        int busy, exp_busy;
        logic [31:0] instr, exp_instr;
        logic [5:0] maddr, exp_maddr;
        bit rd, to, exp_miss;
        mem_lat = 3;
        for (int i = 0; i < 2; i++) begin
            predict(addrs[i], exp_busy, exp_instr, exp_miss, exp_maddr);
            run_fetch(addrs[i], 1'b0, busy, instr, rd, maddr, to);
            n_cmp++;
            if (to || busy !== exp_busy || !exp_miss) begin
                n_fail++;
                $display("FAIL conflict_%0d_busy: got %0d expected %0d", i, busy, exp_busy);
            end
            n_cmp++;
            if (!rd || maddr !== (i == 0 ? 6'h08 : 6'h00)) begin
                n_fail++;
                $display("FAIL conflict_%0d_mem_address: got %h expected %h", i, maddr,
                         (i == 0 ? 6'h08 : 6'h00));
            end
            n_cmp++;
            if (instr !== exp_instr) begin
                n_fail++;
                $display("FAIL conflict_%0d_instruction: got %h expected %h", i, instr, exp_instr);
            end
        end
    endtask

    task automatic test_high_address();
        int busy, exp_busy;
        logic [31:0] instr, exp_instr;
        logic [5:0] maddr, exp_maddr;
        bit rd, to, exp_miss;
        logic [127:0] blk;
        mem_lat = 2;
        blk = mem_blocks[63];
        predict(32'hFFFF_FFFC, exp_busy, exp_instr, exp_miss, exp_maddr);
        run_fetch(32'hFFFF_FFFC, 1'b0, busy, instr, rd, maddr, to);
        n_cmp++;
        if (to || busy !== 4) begin
            n_fail++;
            $display("FAIL high_busy_cycles: got %0d expected 4", busy);
        end
        n_cmp++;
        if (!rd || maddr !== 6'h3F) begin
            n_fail++;
            $display("FAIL high_mem_address: got %h expected 3f", maddr);
        end
        n_cmp++;
        if (instr !== blk[127:96]) begin
            n_fail++;
            $display("FAIL high_instruction: got %h expected %h", instr, blk[127:96]);
        end
    endtask

    task automatic test_random();
        int busy, exp_busy;
        logic [31:0] addr, instr, exp_instr;
        logic [5:0] maddr, exp_maddr;
        bit rd, to, exp_miss;
        for (int i = 0; i < 40; i++) begin
            mem_lat = $urandom_range(1, 6);
            addr = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 7) << 7)
                 | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            predict(addr, exp_busy, exp_instr, exp_miss, exp_maddr);
            run_fetch(addr, 1'b0, busy, instr, rd, maddr, to);
            n_cmp++;
            if (to || busy !== exp_busy || rd !== exp_miss) begin
                n_fail++;
                $display("FAIL rand_%0d_stall addr %h: busy %0d read %b expected %0d %b",
                         i, addr, busy, rd, exp_busy, exp_miss);
            end
            n_cmp++;
            if (exp_miss && maddr !== exp_maddr) begin
                n_fail++;
                $display("FAIL rand_%0d_mem_address: got %h expected %h", i, maddr, exp_maddr);
            end
            n_cmp++;
            if (instr !== exp_instr) begin
                n_fail++;
                $display("FAIL rand_%0d_instruction addr %h: got %h expected %h",
                         i, addr, instr, exp_instr);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int busy, exp_busy;
        logic [31:0] instr, exp_instr;
        logic [5:0] maddr, exp_maddr;
        bit rd, to, exp_miss;
        mem_lat = 10;
        // Index 5 is untouched by earlier tests, so 0x1D0 is a guaranteed miss.
        @(posedge CLK);
        #1;
        ADDRESS = 32'h1D0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'h1D) begin
            n_fail++;
            $display("FAIL midfetch_active: read %b addr %h expected 1 1d", MEM_READ, MEM_ADDRESS);
        end
        #1;
        RESET   = 1'b1;
        ADDRESS = 32'h0;
        #1;
        n_cmp++;
        if (MEM_READ !== 1'b0 || MEM_ADDRESS !== 6'h00) begin
            n_fail++;
            $display("FAIL midfetch_async_clear: read %b addr %h expected 0 00", MEM_READ, MEM_ADDRESS);
        end
        n_cmp++;
        if (BUSYWAIT !== 1'b1) begin
            n_fail++;
            $display("FAIL midfetch_busywait_in_reset: got %b expected 1", BUSYWAIT);
        end
        clear_ref();
        predict(32'h0, exp_busy, exp_instr, exp_miss, exp_maddr);
        run_fetch(32'h0, 1'b1, busy, instr, rd, maddr, to);
        n_cmp++;
        if (to || busy !== 12 || !rd || maddr !== 6'h00) begin
            n_fail++;
            $display("FAIL midfetch_refetch: busy %0d read %b addr %h expected 12 1 00", busy, rd, maddr);
        end
        n_cmp++;
        if (instr !== exp_instr) begin
            n_fail++;
            $display("FAIL midfetch_instruction: got %h expected %h", instr, exp_instr);
        end
    endtask

    task automatic test_zero_latency();
        logic [31:0] addrs [5] = '{32'h1D0, 32'h1D4, 32'h250, 32'h60, 32'h6C};
        int busy, exp_busy;
        logic [31:0] instr, exp_instr;
        logic [5:0] maddr, exp_maddr;
        bit rd, to, exp_miss;
        zero_lat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            predict(addrs[i], exp_busy, exp_instr, exp_miss, exp_maddr);
            run_fetch(addrs[i], 1'b0, busy, instr, rd, maddr, to);
            n_cmp++;
            if (to || busy !== (exp_miss ? 3 : 0) || rd !== exp_miss) begin
                n_fail++;
                $display("FAIL zlat_%0d_stall: busy %0d read %b expected %0d %b",
                         i, busy, rd, (exp_miss ? 3 : 0), exp_miss);
            end
            n_cmp++;
            if (instr !== exp_instr || (exp_miss && maddr !== exp_maddr)) begin
                n_fail++;
                $display("FAIL zlat_%0d_data: instr %h addr %h expected %h %h",
                         i, instr, maddr, exp_instr, exp_maddr);
            end
        end
        zero_lat = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_blocks[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_blocks[0] = 128'h44444444_33333333_22222222_11111111;
        test_reset();
        test_cold_miss();
        test_same_block_hits();
        test_conflict();
        test_high_address();
        test_random();
        test_reset_mid_fetch();
        test_zero_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
